// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_ctrl_pkg
//  Description : Shared types and constants for the UART load controller.
//                Holds the FSM state enum, the load_count width and the
//                address-MSB memory select values. Default RAM/word widths
//                fall back to 14/32 when the system definitions are absent.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef RAM_DEPTH
`define RAM_DEPTH 14
`endif

`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

package uart_ctrl_pkg;

  // Controller phases; RUN must encode as zero so a cleared register is safe.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ARM  = 2'd1,
    ST_LOAD = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam int C_LOAD_COUNT_W = 16;

  // Value of uart_addr[ADDR_W] that steers a word to each RAM.
  localparam logic C_SEL_IMEM = 1'b0;
  localparam logic C_SEL_DMEM = 1'b1;

  // Phase counter width able to hold max(a,b)-1; never narrower than 1 bit.
  function automatic int phase_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_load_controller_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : One-flop rising-edge detector. rise_o is high in the cycle
//                where sig_i is high and was low on the previous clock.
//  Ports       : clk, rst (sync, active-high), sig_i (level in),
//                rise_o (combinational edge strobe)
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic r_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_q <= 1'b0;
    end else begin
      r_prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~r_prev_q;

endmodule

`default_nettype wire

// File: rtl/uart_load_controller.sv
`default_nettype none
// ============================================================================
//  Module      : uart_load_controller
//  Description : Sequences a UART program load against the running CPU.
//                RUN passes CPU memory traffic straight to the RAMs. A rising
//                load_req parks the core (ARM), enables the UART loader
//                (LOAD), steers each received word to imem/dmem by address
//                MSB, then holds the core for a fixed time (HOLD) before
//                releasing it back to RUN.
//  Ports       : clk/rst                       - clock, sync active-high reset
//                load_req                      - load request level (edge used)
//                uart_*                        - loader handshake and words
//                cpu_*                         - CPU memory requests
//                imem_* / dmem_*               - RAM write ports
//                cpu_hold / uart_disable       - core stall, loader reset
//                load_busy/load_done/load_count - status
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_load_controller
  import uart_ctrl_pkg::*;
#(
  parameter int ADDR_W      = `RAM_DEPTH,
  parameter int DATA_W      = `ISA_WIDTH,
  parameter int ARM_CYCLES  = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_req,
  output logic                      uart_disable,
  input  logic                      uart_write_enable,
  input  logic [ADDR_W:0]           uart_addr,
  input  logic [DATA_W-1:0]         uart_data,
  input  logic                      uart_complete,
  output logic                      cpu_hold,
  input  logic [ADDR_W-1:0]         cpu_imem_addr,
  input  logic [ADDR_W-1:0]         cpu_dmem_addr,
  input  logic [DATA_W-1:0]         cpu_dmem_wdata,
  input  logic                      cpu_dmem_we,
  output logic [ADDR_W-1:0]         imem_addr,
  output logic [DATA_W-1:0]         imem_wdata,
  output logic                      imem_we,
  output logic [ADDR_W-1:0]         dmem_addr,
  output logic [DATA_W-1:0]         dmem_wdata,
  output logic                      dmem_we,
  output logic                      load_busy,
  output logic                      load_done,
  output logic [C_LOAD_COUNT_W-1:0] load_count
);

  localparam int              CNT_W      = phase_cnt_w(ARM_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] C_ARM_INIT  = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);

  state_e                    r_state_q;
  logic [CNT_W-1:0]          r_cnt_q;
  logic                      r_uart_disable_q;
  logic                      r_cpu_hold_q;
  logic                      r_busy_q;
  logic                      r_done_q;
  logic [C_LOAD_COUNT_W-1:0] r_count_q;
  logic [ADDR_W:0]           r_wr_addr_q;
  logic [DATA_W-1:0]         r_wr_data_q;
  logic                      r_wr_pend_q;
  logic                      w_load_rise;

  rise_detect u_rise_detect (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (load_req),
    .rise_o (w_load_rise)
  );

  // Control FSM; every status output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q        <= ST_RUN;
      r_cnt_q          <= '0;
      r_uart_disable_q <= 1'b1;
      r_cpu_hold_q     <= 1'b0;
      r_busy_q         <= 1'b0;
      r_done_q         <= 1'b0;
      r_count_q        <= '0;
      r_wr_addr_q      <= '0;
      r_wr_data_q      <= '0;
      r_wr_pend_q      <= 1'b0;
    end else begin
      r_done_q    <= 1'b0;
      // A captured word lives for exactly one cycle on the RAM port.
      r_wr_pend_q <= 1'b0;

      case (r_state_q)
        ST_RUN: begin
          if (w_load_rise) begin
            r_state_q        <= ST_ARM;
            r_cnt_q          <= C_ARM_INIT;
            r_count_q        <= '0;
            r_cpu_hold_q     <= 1'b1;
            r_busy_q         <= 1'b1;
            r_uart_disable_q <= 1'b1;
          end
        end

        ST_ARM: begin
          // Gives the core a few cycles to drain before the loader starts.
          if (r_cnt_q == '0) begin
            r_state_q        <= ST_LOAD;
            r_uart_disable_q <= 1'b0;
          end else begin
            r_cnt_q <= r_cnt_q - 1'b1;
          end
        end

        ST_LOAD: begin
          // A word arriving together with complete is still accepted.
          if (uart_write_enable) begin
            r_wr_addr_q <= uart_addr;
            r_wr_data_q <= uart_data;
            r_wr_pend_q <= 1'b1;
            if (r_count_q != '1) begin
              r_count_q <= r_count_q + 1'b1;
            end
          end
          if (uart_complete) begin
            r_state_q        <= ST_HOLD;
            r_cnt_q          <= C_HOLD_INIT;
            r_uart_disable_q <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (r_cnt_q == '0) begin
            r_state_q    <= ST_RUN;
            r_cpu_hold_q <= 1'b0;
            r_busy_q     <= 1'b0;
            r_done_q     <= 1'b1;
          end else begin
            r_cnt_q <= r_cnt_q - 1'b1;
          end
        end

        default: begin
          r_state_q <= ST_RUN;
        end
      endcase
    end
  end

  // RAM port steering: CPU owns the ports in RUN, the UART write register
  // owns them otherwise (CPU stores are dropped while not running).
  always_comb begin
    imem_addr  = r_wr_addr_q[ADDR_W-1:0];
    imem_wdata = r_wr_data_q;
    imem_we    = 1'b0;
    dmem_addr  = r_wr_addr_q[ADDR_W-1:0];
    dmem_wdata = r_wr_data_q;
    dmem_we    = 1'b0;

    if (r_state_q == ST_RUN) begin
      imem_addr  = cpu_imem_addr;
      dmem_addr  = cpu_dmem_addr;
      dmem_wdata = cpu_dmem_wdata;
      dmem_we    = cpu_dmem_we;
    end else begin
      imem_we = r_wr_pend_q & (r_wr_addr_q[ADDR_W] == C_SEL_IMEM);
      dmem_we = r_wr_pend_q & (r_wr_addr_q[ADDR_W] == C_SEL_DMEM);
    end
  end

  assign uart_disable = r_uart_disable_q;
  assign cpu_hold     = r_cpu_hold_q;
  assign load_busy    = r_busy_q;
  assign load_done    = r_done_q;
  assign load_count   = r_count_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_load_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_load_controller
//  Description : Directed self-checking bench for uart_load_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_load_controller;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_req;
  logic              uart_disable;
  logic              uart_write_enable;
  logic [ADDR_W:0]   uart_addr;
  logic [DATA_W-1:0] uart_data;
  logic              uart_complete;
  logic              cpu_hold;
  logic [ADDR_W-1:0] cpu_imem_addr;
  logic [ADDR_W-1:0] cpu_dmem_addr;
  logic [DATA_W-1:0] cpu_dmem_wdata;
  logic              cpu_dmem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              imem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_we;
  logic              load_busy;
  logic              load_done;
  logic [15:0]       load_count;

  int n_checks = 0;
  int n_errors = 0;

  uart_load_controller #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .ARM_CYCLES  (2),
    .HOLD_CYCLES (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .load_req          (load_req),
    .uart_disable      (uart_disable),
    .uart_write_enable (uart_write_enable),
    .uart_addr         (uart_addr),
    .uart_data         (uart_data),
    .uart_complete     (uart_complete),
    .cpu_hold          (cpu_hold),
    .cpu_imem_addr     (cpu_imem_addr),
    .cpu_dmem_addr     (cpu_dmem_addr),
    .cpu_dmem_wdata    (cpu_dmem_wdata),
    .cpu_dmem_we       (cpu_dmem_we),
    .imem_addr         (imem_addr),
    .imem_wdata        (imem_wdata),
    .imem_we           (imem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_we           (dmem_we),
    .load_busy         (load_busy),
    .load_done         (load_done),
    .load_count        (load_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst               = 1'b1;
    load_req          = 1'b0;
    uart_write_enable = 1'b0;
    uart_addr         = '0;
    uart_data         = '0;
    uart_complete     = 1'b0;
    cpu_imem_addr     = 14'h0100;
    cpu_dmem_addr     = '0;
    cpu_dmem_wdata    = '0;
    cpu_dmem_we       = 1'b0;

    step();
    step();
    // Reset state
    check("rst_uart_disable", 32'(uart_disable), 32'd1);
    check("rst_cpu_hold",     32'(cpu_hold),     32'd0);
    check("rst_busy",         32'(load_busy),    32'd0);
    check("rst_done",         32'(load_done),    32'd0);
    check("rst_count",        32'(load_count),   32'd0);
    check("rst_imem_we",      32'(imem_we),      32'd0);
    check("rst_dmem_we",      32'(dmem_we),      32'd0);
    rst = 1'b0;
    step();

    // RUN: CPU store passes straight through in the same cycle
    cpu_dmem_addr  = 14'h0010;
    cpu_dmem_wdata = 32'hDEADBEEF;
    cpu_dmem_we    = 1'b1;
    #1;
    check("run_dmem_we",    32'(dmem_we),    32'd1);
    check("run_dmem_addr",  32'(dmem_addr),  32'h10);
    check("run_dmem_wdata", dmem_wdata,      32'hDEADBEEF);
    check("run_imem_addr",  32'(imem_addr),  32'h100);
    check("run_imem_we",    32'(imem_we),    32'd0);

    // load_req edge sampled at the end of this cycle (cycle N)
    load_req = 1'b1;
    step();                                  // N+1: ARM
    check("arm_cpu_hold",     32'(cpu_hold),     32'd1);
    check("arm_busy",         32'(load_busy),    32'd1);
    check("arm_uart_disable", 32'(uart_disable), 32'd1);
    #1;
    check("arm_cpu_store_dropped", 32'(dmem_we), 32'd0);
    cpu_dmem_we = 1'b0;
    step();                                  // N+2: still ARM
    check("arm2_uart_disable", 32'(uart_disable), 32'd1);
    step();                                  // N+3: LOAD
    check("load_uart_disable", 32'(uart_disable), 32'd0);
    check("load_cpu_hold",     32'(cpu_hold),     32'd1);

    // Two loader words: imem then dmem
    uart_write_enable = 1'b1;
    uart_addr         = 15'h0004;
    uart_data         = 32'h12345678;
    step();
    check("w1_imem_we",    32'(imem_we),   32'd1);
    check("w1_imem_addr",  32'(imem_addr), 32'h4);
    check("w1_imem_wdata", imem_wdata,     32'h12345678);
    check("w1_dmem_we",    32'(dmem_we),   32'd0);
    uart_addr = 15'h4008;
    uart_data = 32'hCAFEF00D;
    step();
    check("w2_dmem_we",    32'(dmem_we),   32'd1);
    check("w2_dmem_addr",  32'(dmem_addr), 32'h8);
    check("w2_dmem_wdata", dmem_wdata,     32'hCAFEF00D);
    check("w2_imem_we",    32'(imem_we),   32'd0);
    uart_write_enable = 1'b0;
    step();
    check("idle_imem_we",   32'(imem_we),    32'd0);
    check("idle_dmem_we",   32'(dmem_we),    32'd0);
    check("idle_dmem_addr", 32'(dmem_addr),  32'h8);
    check("count_after_2",  32'(load_count), 32'd2);

    // load_req re-edge during LOAD is ignored
    load_req = 1'b0;
    step();
    load_req = 1'b1;
    step();
    step();
    check("load_reedge_disable", 32'(uart_disable), 32'd0);
    check("load_reedge_count",   32'(load_count),   32'd2);

    // Write and complete in the same cycle (cycle M)
    uart_write_enable = 1'b1;
    uart_complete     = 1'b1;
    uart_addr         = 15'h0010;
    uart_data         = 32'hA5A5A5A5;
    step();                                  // M+1: HOLD, word retires
    uart_write_enable = 1'b0;
    uart_complete     = 1'b0;
    check("wc_imem_we",      32'(imem_we),      32'd1);
    check("wc_imem_addr",    32'(imem_addr),    32'h10);
    check("wc_imem_wdata",   imem_wdata,        32'hA5A5A5A5);
    check("wc_uart_disable", 32'(uart_disable), 32'd1);
    check("wc_count",        32'(load_count),   32'd3);
    for (int i = 2; i <= 16; i++) begin
      load_req = i[0];
      step();                                // M+2 .. M+16
      check("hold_cpu_hold", 32'(cpu_hold),  32'd1);
      check("hold_done",     32'(load_done), 32'd0);
      check("hold_imem_we",  32'(imem_we),   32'd0);
    end
    check("hold_count", 32'(load_count), 32'd3);
    load_req = 1'b0;
    step();                                  // M+17: back to RUN
    check("end_done",     32'(load_done),    32'd1);
    check("end_cpu_hold", 32'(cpu_hold),     32'd0);
    check("end_busy",     32'(load_busy),    32'd0);
    check("end_count",    32'(load_count),   32'd3);
    step();
    check("done_single_pulse", 32'(load_done),    32'd0);
    check("run_uart_disable",  32'(uart_disable), 32'd1);
    cpu_dmem_we = 1'b1;
    #1;
    check("run_again_dmem_we", 32'(dmem_we), 32'd1);
    cpu_dmem_we = 1'b0;

    // Second load, reset mid-LOAD with a write pending
    load_req = 1'b1;
    step();
    check("l2_count_cleared", 32'(load_count), 32'd0);
    check("l2_cpu_hold",      32'(cpu_hold),   32'd1);
    step();
    step();
    check("l2_load_disable", 32'(uart_disable), 32'd0);
    uart_write_enable = 1'b1;
    uart_addr         = 15'h4020;
    uart_data         = 32'h0BADF00D;
    rst               = 1'b1;
    step();
    rst               = 1'b0;
    uart_write_enable = 1'b0;
    check("rst_mid_imem_we",      32'(imem_we),      32'd0);
    check("rst_mid_dmem_we",      32'(dmem_we),      32'd0);
    check("rst_mid_uart_disable", 32'(uart_disable), 32'd1);
    check("rst_mid_cpu_hold",     32'(cpu_hold),     32'd0);
    check("rst_mid_busy",         32'(load_busy),    32'd0);
    check("rst_mid_count",        32'(load_count),   32'd0);
    #1;
    check("rst_mid_dmem_pass", 32'(dmem_addr), 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_load_controller.md
# uart_load_controller

Sequences the UART programming path (`uart_unit`) against the running CPU. It parks and holds the core, enables the UART loader, and steers each received word into instruction or data memory by address MSB. When loading completes it releases the core through a timed reset hold. It sits between `uart_unit`, the CPU memory ports and the two block RAMs, and owns the RAM write ports.

## Interface
Parameters:
- `ADDR_W`, default `` `RAM_DEPTH `` (14): word-address width of each RAM.
- `DATA_W`, default `` `ISA_WIDTH `` (32): memory word width.
- `ARM_CYCLES`, default 2: CPU drain cycles before the loader is enabled.
- `HOLD_CYCLES`, default 16: cycles the CPU is held after loading completes.

Ports (one clock; reset is synchronous and active-high; all inputs synchronous to `clk`):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `load_req` in 1: mode switch; a rising edge requests a load.
- `uart_disable` out 1: to `uart_unit` reset input.
- `uart_write_enable` in 1: word-valid strobe from `uart_unit`.
- `uart_addr` in ADDR_W+1: MSB 0 selects imem, 1 selects dmem; low ADDR_W bits are the word address.
- `uart_data` in DATA_W: loader word.
- `uart_complete` in 1: level, loader finished.
- `cpu_hold` out 1: stall/reset to the core.
- `cpu_imem_addr` in ADDR_W: CPU instruction-fetch address.
- `cpu_dmem_addr` in ADDR_W: CPU data address.
- `cpu_dmem_wdata` in DATA_W: CPU store data.
- `cpu_dmem_we` in 1: CPU store enable.
- `imem_addr` out ADDR_W, `imem_wdata` out DATA_W, `imem_we` out 1: instruction RAM port.
- `dmem_addr` out ADDR_W, `dmem_wdata` out DATA_W, `dmem_we` out 1: data RAM port.
- `load_busy` out 1: high in ARM, LOAD and HOLD.
- `load_done` out 1: one-cycle pulse on the return to RUN.
- `load_count` out 16: words written during the last or current load.

## Operation
- States: RUN, ARM, LOAD, HOLD. Reset enters RUN.
- **RUN**
  - `uart_disable`=1, `cpu_hold`=0.
  - RAM ports pass the CPU signals through combinationally; `imem_we`=0.
  - A `load_req` rising edge moves to ARM, clears `load_count` and loads the phase counter with ARM_CYCLES-1.
- **ARM**
  - `cpu_hold`=1, `uart_disable`=1, all RAM `we`=0.
  - The counter decrements each cycle; at 0 the FSM moves to LOAD.
- **LOAD**
  - `uart_disable`=0, `cpu_hold`=1.
  - Each cycle with `uart_write_enable`=1 registers addr/data and asserts exactly one of `imem_we`/`dmem_we` the next cycle, selected by `uart_addr[ADDR_W]`.
  - `load_count` increments per accepted word and saturates at 16'hFFFF.
  - `uart_complete`=1 moves to HOLD and loads the counter with HOLD_CYCLES-1.
  - If `uart_write_enable` and `uart_complete` are high in the same cycle, the word is still written.
- **HOLD**
  - `uart_disable`=1, `cpu_hold`=1, no new writes; the last registered write still retires.
  - At count 0 the FSM moves to RUN and pulses `load_done`.
- `load_req` edges outside RUN are ignored. Holding `load_req` high does not retrigger.
- CPU stores (`cpu_dmem_we`) outside RUN are dropped.
- In any state other than RUN, the RAM ports are driven from the UART write register. When no write is pending, addr and data hold their last values and `we`=0.
- `rst` in any state: immediate return to RUN with all reset values; a pending write is discarded.

## Timing
- Reset values:
  - `uart_disable`=1, `cpu_hold`=0, `load_busy`=0, `load_done`=0.
  - `load_count`=0, `imem_we`=`dmem_we`=0, write register=0.
  - Edge-detect history=0, so a `load_req` already high at reset does not trigger.
- `load_req` edge at cycle N: ARM occupies N+1..N+ARM_CYCLES, and `uart_disable` falls at N+ARM_CYCLES+1.
- UART write latency: 1 cycle (strobe at N, RAM `we` at N+1). Throughput is one word per cycle.
- `uart_complete` at N: `uart_disable` rises at N+1 and HOLD lasts HOLD_CYCLES cycles. `load_done` and `cpu_hold`=0 occur in the same cycle, at N+HOLD_CYCLES+1.

## Structure
- Shared package `uart_ctrl_pkg`: state enum (RUN/ARM/LOAD/HOLD, 2-bit), the `load_count` width constant, and the address-MSB select constants. Widths come from `definitions.v`.
- One natural sub-module: `rise_detect`, a one-flop rising-edge detector for `load_req`.
- Phase counter width: $clog2(max(ARM_CYCLES, HOLD_CYCLES)).

## Test plan
- Reset, then idle: `uart_disable`=1, `cpu_hold`=0. CPU `dmem_we`=1 at addr 0x10 with 0xDEADBEEF appears on the dmem port the same cycle.
- `load_req` rises at cycle 5 (ARM_CYCLES=2): `cpu_hold`=1 at cycle 6 and `uart_disable`=0 at cycle 8.
- In LOAD, write (addr 0x0004, 0x12345678) then (addr 0x4008, 0xCAFEF00D):
  - `imem_we` pulses at addr 4, then `dmem_we` pulses at addr 8, each one cycle after its strobe.
  - `load_count`=2.
- `uart_write_enable` and `uart_complete` in the same cycle: the word is written, then HOLD for 16 cycles. `load_done` pulses once with `cpu_hold` falling.
- Edges on `load_req` during LOAD and HOLD: no state change, and `load_count` is unaffected.
- `rst` asserted mid-LOAD with a write pending: next cycle all RAM `we`=0, state RUN, `uart_disable`=1, `load_count`=0.
